// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg
// Shared encodings for the write-back stage: register-file source select,
// load size and FSM state values. Imported by writeback_unit and load_align.
package writeback_unit_pkg;

  // MemtoReg source select encodings
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  // LoadSize encodings
  localparam logic [1:0] LS_BYTE  = 2'd0;
  localparam logic [1:0] LS_HALF  = 2'd1;
  localparam logic [1:0] LS_WORD  = 2'd2;
  localparam logic [1:0] LS_DWORD = 2'd3;

  // FSM state encodings
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

endpackage

// File: rtl/writeback_unit_load.sv
// load_align
// Combinational load extraction: selects the addressed little-endian lanes
// of the memory word, extends them to DATA_W and flags unaligned accesses.
// Ports:
//   ReadData   in  DATA_W  raw memory read data
//   Offset     in  OFF_W   byte offset within the memory word
//   LoadSize   in  2       byte / half / word / dword
//   LoadSigned in  1       sign-extend when 1, zero-extend when 0
//   LoadData   out DATA_W  extracted, extended value
//   Misaligned out 1       access is not naturally aligned
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] ReadData,
  input  logic [OFF_W-1:0]  Offset,
  input  logic [1:0]        LoadSize,
  input  logic              LoadSigned,
  output logic [DATA_W-1:0] LoadData,
  output logic              Misaligned
);

  logic [1:0]        size_eff_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] mask_s;
  logic [7:0]        nbits_s;
  logic              sign_s;

  // Lane select, field width, sign bit and alignment check
  always_comb begin
    size_eff_s = LoadSize;
    nbits_s    = 8'd8;
    sign_s     = 1'b0;
    Misaligned = 1'b0;
    // A 32-bit datapath has no dword; it degrades to a word load
    if ((DATA_W == 32) && (LoadSize == LS_DWORD)) begin
      size_eff_s = LS_WORD;
    end else begin
      size_eff_s = LoadSize;
    end
    // Lowest addressed lane moves to bit 0
    shifted_s = ReadData >> {Offset, 3'b000};
    case (size_eff_s)
      LS_BYTE: begin
        nbits_s    = 8'd8;
        sign_s     = shifted_s[7];
        Misaligned = 1'b0;
      end
      LS_HALF: begin
        nbits_s    = 8'd16;
        sign_s     = shifted_s[15];
        Misaligned = Offset[0];
      end
      LS_WORD: begin
        nbits_s    = 8'd32;
        sign_s     = shifted_s[31];
        Misaligned = (Offset[1:0] != 2'b00);
      end
      LS_DWORD: begin
        nbits_s    = 8'(DATA_W);
        sign_s     = shifted_s[DATA_W-1];
        Misaligned = (Offset != {OFF_W{1'b0}});
      end
      default: begin
        nbits_s    = 8'd8;
        sign_s     = shifted_s[7];
        Misaligned = 1'b0;
      end
    endcase
    // Shifting by DATA_W yields zero, so a full-width field gets an all-ones mask
    mask_s   = ~({DATA_W{1'b1}} << nbits_s);
    LoadData = (shifted_s & mask_s) | ({DATA_W{sign_s & LoadSigned}} & ~mask_s);
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
// MIPS write-back stage with four register-file sources (ALU, load, link,
// immediate), sized/extended loads and a wait state for variable-latency
// memory. Produces the registered RegWrite / WriteReg / WriteDataReg triple.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   InValid / InReady   handshake with the MEM stage
//   MemtoReg            source select
//   ALUOut, LinkAddr, ImmData  candidate sources (ALUOut low bits = offset)
//   LoadSize, LoadSigned       load shape
//   RegWriteIn, WriteRegIn     write intent and destination
//   ReadData, ReadValid        memory return
//   RegWrite, WriteReg, WriteDataReg  register-file write port
//   Misaligned          one-cycle pulse on an unaligned load
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            MemtoReg,
  input  logic [DATA_W-1:0]     ALUOut,
  input  logic [DATA_W-1:0]     LinkAddr,
  input  logic [DATA_W-1:0]     ImmData,
  input  logic [1:0]            LoadSize,
  input  logic                  LoadSigned,
  input  logic                  RegWriteIn,
  input  logic [REG_ADDR_W-1:0] WriteRegIn,
  input  logic [DATA_W-1:0]     ReadData,
  input  logic                  ReadValid,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteDataReg,
  output logic                  Misaligned
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  logic [0:0]            state_r;
  logic [OFF_W-1:0]      lat_off_r;
  logic [1:0]            lat_size_r;
  logic                  lat_signed_r;
  logic                  lat_rw_r;
  logic [REG_ADDR_W-1:0] lat_wreg_r;

  logic                  regwrite_r;
  logic                  misaligned_r;
  logic [REG_ADDR_W-1:0] wreg_r;
  logic [DATA_W-1:0]     wdata_r;

  logic [DATA_W-1:0]     src_data_s;
  logic [DATA_W-1:0]     load_data_s;
  logic                  load_mis_s;

  // Non-load source select for same-cycle retirement
  always_comb begin
    src_data_s = ALUOut;
    case (MemtoReg)
      WB_ALU:  src_data_s = ALUOut;
      WB_LINK: src_data_s = LinkAddr;
      WB_IMM:  src_data_s = ImmData;
      default: src_data_s = ALUOut;
    endcase
  end

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .ReadData   (ReadData),
    .Offset     (lat_off_r),
    .LoadSize   (lat_size_r),
    .LoadSigned (lat_signed_r),
    .LoadData   (load_data_s),
    .Misaligned (load_mis_s)
  );

  // FSM, load latches and registered write-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      lat_off_r    <= {OFF_W{1'b0}};
      lat_size_r   <= 2'b00;
      lat_signed_r <= 1'b0;
      lat_rw_r     <= 1'b0;
      lat_wreg_r   <= {REG_ADDR_W{1'b0}};
      regwrite_r   <= 1'b0;
      misaligned_r <= 1'b0;
      wreg_r       <= {REG_ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
    end else begin
      // Strobes are single-cycle unless re-asserted below
      regwrite_r   <= 1'b0;
      misaligned_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (InValid) begin
            if (MemtoReg == WB_MEM) begin
              lat_off_r    <= ALUOut[OFF_W-1:0];
              lat_size_r   <= LoadSize;
              lat_signed_r <= LoadSigned;
              lat_rw_r     <= RegWriteIn;
              lat_wreg_r   <= WriteRegIn;
              state_r      <= S_WAIT_MEM;
            end else begin
              wreg_r     <= WriteRegIn;
              wdata_r    <= src_data_s;
              regwrite_r <= RegWriteIn && (WriteRegIn != {REG_ADDR_W{1'b0}});
            end
          end
        end
        S_WAIT_MEM: begin
          // InValid is not accepted here even when ReadValid retires the load
          if (ReadValid) begin
            wreg_r       <= lat_wreg_r;
            wdata_r      <= load_data_s;
            regwrite_r   <= lat_rw_r && (lat_wreg_r != {REG_ADDR_W{1'b0}}) && !load_mis_s;
            misaligned_r <= load_mis_s;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign InReady      = (state_r == S_IDLE);
  assign RegWrite     = regwrite_r;
  assign Misaligned   = misaligned_r;
  assign WriteReg     = wreg_r;
  assign WriteDataReg = wdata_r;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  MemtoReg = 2'd0;
  logic [31:0] ALUOut = 32'd0;
  logic [31:0] LinkAddr = 32'd0;
  logic [31:0] ImmData = 32'd0;
  logic [1:0]  LoadSize = 2'd0;
  logic        LoadSigned = 1'b0;
  logic        RegWriteIn = 1'b0;
  logic [4:0]  WriteRegIn = 5'd0;
  logic [31:0] ReadData = 32'd0;
  logic        ReadValid = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteDataReg;
  logic        Misaligned;

  int tests = 0;
  int fails = 0;

  writeback_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .MemtoReg(MemtoReg), .ALUOut(ALUOut), .LinkAddr(LinkAddr), .ImmData(ImmData),
    .LoadSize(LoadSize), .LoadSigned(LoadSigned), .RegWriteIn(RegWriteIn),
    .WriteRegIn(WriteRegIn), .ReadData(ReadData), .ReadValid(ReadValid),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteDataReg(WriteDataReg),
    .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] link;
    logic [31:0] imm;
    logic [1:0]  lsize;
    logic        lsigned;
    logic        rwin;
    logic [4:0]  wreg;
    logic [31:0] rdata;
    int          k;
    logic        exp_rw;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        chk_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction from byte lanes and arithmetic sign extension
  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                             input int size, input bit sgn, output bit mis);
    int n;
    longint v;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++)
      if (off + i < 4) v = v | (longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i));
    if (sgn && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
    mis = (off % n) != 0;
    return v[31:0];
  endfunction

  // Issue one instruction; loads wait k cycles then return rdata. Returns at the retire-visible cycle.
  task automatic run(input vec_t v, input string tag);
    check({tag, ".inready_pre"}, {31'd0, InReady}, 32'd1);
    MemtoReg = v.mtr; ALUOut = v.alu; LinkAddr = v.link; ImmData = v.imm;
    LoadSize = v.lsize; LoadSigned = v.lsigned; RegWriteIn = v.rwin; WriteRegIn = v.wreg;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    if (v.mtr == 2'd1) begin
      for (int c = 1; c < v.k; c++) begin
        check({tag, ".inready_wait"}, {31'd0, InReady}, 32'd0);
        check({tag, ".rw_wait"}, {31'd0, RegWrite}, 32'd0);
        tick();
      end
      check({tag, ".inready_wait"}, {31'd0, InReady}, 32'd0);
      ReadData = v.rdata;
      ReadValid = 1'b1;
      tick();
      ReadValid = 1'b0;
      ReadData = $urandom;
    end
    check({tag, ".regwrite"}, {31'd0, RegWrite}, {31'd0, v.exp_rw});
    check({tag, ".misaligned"}, {31'd0, Misaligned}, {31'd0, v.exp_mis});
    check({tag, ".writereg"}, {27'd0, WriteReg}, {27'd0, v.wreg});
    if (v.chk_data) check({tag, ".wdata"}, WriteDataReg, v.exp_data);
    check({tag, ".inready_post"}, {31'd0, InReady}, 32'd1);
  endtask

  function automatic vec_t mk(input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] link,
                              input logic [31:0] imm, input logic [1:0] ls, input logic sg,
                              input logic rw, input logic [4:0] wr, input logic [31:0] rd, input int k,
                              input logic erw, input logic [31:0] ed, input logic em, input logic cd);
    vec_t v;
    v.mtr = mtr; v.alu = alu; v.link = link; v.imm = imm; v.lsize = ls; v.lsigned = sg;
    v.rwin = rw; v.wreg = wr; v.rdata = rd; v.k = k;
    v.exp_rw = erw; v.exp_data = ed; v.exp_mis = em; v.chk_data = cd;
    return v;
  endfunction

  initial begin
    vec_t rv;
    bit mis;
    logic [31:0] ed;
    logic [4:0] held;

    // Reset state
    #2;
    check("rst.regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst.misaligned", {31'd0, Misaligned}, 32'd0);
    check("rst.writereg", {27'd0, WriteReg}, 32'd0);
    check("rst.wdata", WriteDataReg, 32'd0);
    check("rst.inready", {31'd0, InReady}, 32'd1);
    tick();
    reset = 1'b0;
    tick();

    vecs[0]  = mk(2'd0, 32'h0000_1234, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 5'd8, 32'h0, 1, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    vecs[1]  = mk(2'd1, 32'h1000_0003, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 5'd9, 32'h80FF_0000, 3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
    vecs[2]  = mk(2'd1, 32'h1000_0002, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 5'd10, 32'hBEEF_1234, 1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b1);
    vecs[3]  = mk(2'd1, 32'h1000_0001, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 5'd11, 32'hBEEF_1234, 2, 1'b0, 32'h0, 1'b1, 1'b0);
    vecs[4]  = mk(2'd2, 32'h0, 32'h0040_0008, 32'h0, 2'd0, 1'b0, 1'b1, 5'd31, 32'h0, 1, 1'b1, 32'h0040_0008, 1'b0, 1'b1);
    vecs[5]  = mk(2'd2, 32'h0, 32'h0040_0008, 32'h0, 2'd0, 1'b0, 1'b1, 5'd0, 32'h0, 1, 1'b0, 32'h0040_0008, 1'b0, 1'b1);
    vecs[6]  = mk(2'd3, 32'h0, 32'h0, 32'h1234_0000, 2'd0, 1'b0, 1'b0, 5'd5, 32'h0, 1, 1'b0, 32'h1234_0000, 1'b0, 1'b1);
    vecs[7]  = mk(2'd1, 32'h0000_0100, 32'h0, 32'h0, 2'd2, 1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    vecs[8]  = mk(2'd1, 32'h0000_0200, 32'h0, 32'h0, 2'd3, 1'b1, 1'b1, 5'd13, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
    vecs[9]  = mk(2'd1, 32'h0000_0202, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 5'd14, 32'h1111_2222, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    vecs[10] = mk(2'd1, 32'h0000_0301, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd15, 32'h0000_AB00, 4, 1'b1, 32'h0000_00AB, 1'b0, 1'b1);
    vecs[11] = mk(2'd1, 32'h0000_0400, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 5'd16, 32'h0000_8001, 1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
      // Strobes must drop after one cycle while WriteReg holds
      tick();
      check($sformatf("vec%0d.rw_pulse", i), {31'd0, RegWrite}, 32'd0);
      check($sformatf("vec%0d.mis_pulse", i), {31'd0, Misaligned}, 32'd0);
      check($sformatf("vec%0d.wreg_hold", i), {27'd0, WriteReg}, {27'd0, vecs[i].wreg});
    end

    // Back-to-back non-load acceptance
    MemtoReg = 2'd0; RegWriteIn = 1'b1; InValid = 1'b1;
    ALUOut = 32'hAAAA_0001; WriteRegIn = 5'd3;
    tick();
    check("b2b.first.data", WriteDataReg, 32'hAAAA_0001);
    check("b2b.first.rw", {31'd0, RegWrite}, 32'd1);
    ALUOut = 32'hBBBB_0002; WriteRegIn = 5'd4;
    tick();
    InValid = 1'b0;
    check("b2b.second.data", WriteDataReg, 32'hBBBB_0002);
    check("b2b.second.wreg", {27'd0, WriteReg}, 32'd4);
    check("b2b.second.rw", {31'd0, RegWrite}, 32'd1);
    tick();

    // InValid together with ReadValid in WAIT_MEM: load retires, new instr waits
    MemtoReg = 2'd1; ALUOut = 32'h0; LoadSize = 2'd2; LoadSigned = 1'b0; WriteRegIn = 5'd20;
    InValid = 1'b1;
    tick();
    MemtoReg = 2'd3; ImmData = 32'h5555_0000; WriteRegIn = 5'd21;
    ReadData = 32'h7777_8888; ReadValid = 1'b1;
    tick();
    ReadValid = 1'b0;
    check("sim.load.data", WriteDataReg, 32'h7777_8888);
    check("sim.load.wreg", {27'd0, WriteReg}, 32'd20);
    check("sim.inready", {31'd0, InReady}, 32'd1);
    tick();
    InValid = 1'b0;
    check("sim.imm.data", WriteDataReg, 32'h5555_0000);
    check("sim.imm.wreg", {27'd0, WriteReg}, 32'd21);
    check("sim.imm.rw", {31'd0, RegWrite}, 32'd1);
    tick();

    // Reset in WAIT_MEM discards the load
    MemtoReg = 2'd1; ALUOut = 32'h0; LoadSize = 2'd2; WriteRegIn = 5'd7; InValid = 1'b1;
    tick();
    InValid = 1'b0;
    check("rstwait.inready_wait", {31'd0, InReady}, 32'd0);
    reset = 1'b1;
    #1;
    check("rstwait.inready_async", {31'd0, InReady}, 32'd1);
    tick();
    reset = 1'b0;
    ReadData = 32'h1234_5678; ReadValid = 1'b1;
    tick();
    ReadValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstwait.no_rw", {31'd0, RegWrite}, 32'd0);
      check("rstwait.inready", {31'd0, InReady}, 32'd1);
      tick();
    end
    check("rstwait.wreg", {27'd0, WriteReg}, 32'd0);

    // Randomized instructions against the reference model
    held = WriteReg;
    for (int i = 0; i < 200; i++) begin
      rv.mtr = 2'($urandom_range(0, 3));
      rv.alu = $urandom; rv.link = $urandom; rv.imm = $urandom;
      rv.lsize = 2'($urandom_range(0, 3)); rv.lsigned = 1'($urandom);
      rv.rwin = 1'($urandom); rv.wreg = 5'($urandom_range(0, 31));
      rv.rdata = $urandom; rv.k = $urandom_range(1, 4);
      if (rv.mtr == 2'd1) begin
        ed = model_load(rv.rdata, int'(rv.alu[1:0]), int'(rv.lsize), rv.lsigned, mis);
        rv.exp_mis = mis;
        rv.chk_data = !mis;
      end else begin
        ed = (rv.mtr == 2'd0) ? rv.alu : (rv.mtr == 2'd2) ? rv.link : rv.imm;
        rv.exp_mis = 1'b0;
        rv.chk_data = 1'b1;
      end
      rv.exp_data = ed;
      rv.exp_rw = rv.rwin && (rv.wreg != 5'd0) && !rv.exp_mis;
      run(rv, $sformatf("rand%0d", i));
      held = rv.wreg;
    end
    tick();
    check("rand.final_hold", {27'd0, WriteReg}, {27'd0, held});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
